buffer_linhas: RTL
==================

# buffer_linhas

Streaming 3×3 window generator for the Sobel path. It accepts raster-order 8-bit grayscale pixels, keeps the two previous image rows in internal line memories, and presents a complete 3×3 neighbourhood as three 24-bit rows. It sits directly upstream of `convolucao` and drives that block's `linha1`/`linha2`/`linha3` inputs.

## Interface
- `LARGURA`, default 320: image width in pixels; must be ≥ 3.
- `ALTURA`, default 240: image height in rows; must be ≥ 3.
- `clk` input, 1 bit: the block's only clock; everything is rising-edge.
- `reset` input, 1 bit: synchronous, active-high.
- `pixel_in` input, 8 bits: incoming pixel, unsigned.
- `pixel_valido` input, 1 bit: `pixel_in` is accepted on the rising edge while this is high.
- `inicio_quadro` input, 1 bit: start-of-frame marker. Present only with `BUFFER_LINHAS_SOF_EN`.
- `linha1` output, 24 bits: top window row (image row r-2).
- `linha2` output, 24 bits: middle window row (r-1).
- `linha3` output, 24 bits: bottom window row (r, the current row).
- `janela_valida` output, 1 bit: one-cycle strobe; the window is complete.

## Operation
- Packing, all three rows: `[23:16]` = column c-2, `[15:8]` = c-1, `[7:0]` = c. This matches the MSB-first slicing in `convolucao`.
- Counters:
  - `col` runs 0..LARGURA-1 and wraps to 0, incrementing `lin`.
  - `lin` runs 0..ALTURA-1 and wraps to 0.
  - Both advance only on an accepted pixel.
- Line memories: `mem_a` holds row r-1 and `mem_b` holds row r-2. Each is LARGURA×8 with asynchronous read.
- On an accepted pixel at (`lin`, `col`):
  - Read `a = mem_a[col]` and `b = mem_b[col]`.
  - Write `mem_b[col] <= a` and `mem_a[col] <= pixel_in`.
  - Shift the window: `linha1 <= {linha1[15:0], b}`, `linha2 <= {linha2[15:0], a}`, `linha3 <= {linha3[15:0], pixel_in}`.
  - Set `janela_valida <= (lin ≥ 2) && (col ≥ 2)`.
- Cycle with no accepted pixel:
  - Window registers and memories hold.
  - `janela_valida <= 0`.
- Row boundaries: at `col` = 0 or 1 the window holds stale columns from the previous row. This is not an error; validity gating hides it.
- Windows per frame: exactly (LARGURA-2)·(ALTURA-2). There is no border padding.
- Frame wrap: after the last pixel (`lin` = ALTURA-1, `col` = LARGURA-1), both counters return to 0. The first valid window of the next frame appears again at `lin` = 2, `col` = 2. Rows left from the old frame in memory are never flagged valid.

## Timing
- Latency: outputs update on the same edge that accepts the pixel. They are visible the cycle after `pixel_valido` was sampled high.
- Throughput: one pixel per clock; `pixel_valido` may stay high indefinitely.
- Stalls: gaps of any length are tolerated. Outputs hold their values, but `janela_valida` is a strobe and is not held.
- Reset behaviour:
  - `linha1`, `linha2`, `linha3` = 24'h000000.
  - `janela_valida` = 0.
  - `col` = `lin` = 0.
  - Memory contents are not cleared.
  - `reset` beats `pixel_valido` in the same cycle.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).
- No back-pressure: `convolucao` consumes every cycle.

## Configuration
- `BUFFER_LINHAS_SOF_EN` defined:
  - The `inicio_quadro` port exists.
  - When sampled high together with `pixel_valido`, that pixel is treated as (0,0): the counters reload, then advance normally.
  - `janela_valida` is 0 for that pixel.
  - `inicio_quadro` without `pixel_valido` is ignored.
- Macro undefined:
  - The port is absent.
  - Framing relies only on counter wrap, so upstream must never drop or insert pixels.

## Structure
- Package `buffer_linhas_pkg` holds:
  - `PIXEL_W` = 8 and `JANELA_W` = 24.
  - The pixel typedef, shared with `convolucao`.
- Sub-module `memoria_linha`: a parameterised LARGURA×8 single-write, asynchronous-read array. It is instantiated twice, for `mem_a` and `mem_b`.

## Test plan
Unless stated otherwise, LARGURA=4, ALTURA=4, continuous stream, pixel value = 16·lin + col.
- First window: when pixel 8'h22 is accepted, the next cycle shows `linha1`=24'h000102, `linha2`=24'h101112, `linha3`=24'h202122, `janela_valida`=1.
- Full frame: exactly 4 strobes, for centre windows ending at 22, 23, 32, 33. For the last one, `linha3`=24'h313233.
- Two back-to-back frames: the second frame again shows no strobe before its pixel (2,2), and 4 strobes in total.
- Random `pixel_valido` gaps: window contents are identical to the continuous run, and the strobe count is unchanged.
- Reset asserted after pixel (2,3), then the stream restarts at 00: all outputs 0 the cycle after reset, and the first strobe comes only after the new (2,2).
- With `BUFFER_LINHAS_SOF_EN`: assert `inicio_quadro` at the old (1,1). The first strobe is 10 accepted pixels later, at the new (2,2).

Source files
------------

// File: rtl/buffer_linhas_pkg.sv
// Shared widths and pixel type for the Sobel window path.
// Also imported by convolucao.
package buffer_linhas_pkg;

  localparam int PIXEL_W  = 8;
  localparam int JANELA_W = 3 * PIXEL_W;

  typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/buffer_linhas_memoria_linha.sv
// One image line of pixels.
// Single write port, asynchronous read.
module memoria_linha
  import buffer_linhas_pkg::*;
#(
  parameter int LARGURA = 320,
  parameter int AW      = $clog2(LARGURA)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  pixel_t        i_dado,
  output pixel_t        o_dado
);

  pixel_t r_mem [LARGURA];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_dado;
  end

  assign o_dado = r_mem[i_addr];

endmodule

// File: rtl/buffer_linhas.sv
// Streaming 3x3 window generator; two line memories hold rows r-1/r-2.
// Define BUFFER_LINHAS_SOF_EN to add the inicio_quadro frame-start input.
module buffer_linhas
  import buffer_linhas_pkg::*;
#(
  parameter int LARGURA = 320,
  parameter int ALTURA  = 240
) (
  input  logic                clk,
  input  logic                reset,
  input  pixel_t              pixel_in,
  input  logic                pixel_valido,
`ifdef BUFFER_LINHAS_SOF_EN
  input  logic                inicio_quadro,
`endif
  output logic [JANELA_W-1:0] linha1,
  output logic [JANELA_W-1:0] linha2,
  output logic [JANELA_W-1:0] linha3,
  output logic                janela_valida
);

  localparam int CW = $clog2(LARGURA);
  localparam int LW = $clog2(ALTURA);
  localparam logic [CW-1:0] COL_MAX = CW'(LARGURA - 1);
  localparam logic [LW-1:0] LIN_MAX = LW'(ALTURA - 1);

  logic [CW-1:0] r_col;
  logic [LW-1:0] r_lin;
  logic [CW-1:0] w_col;
  logic [LW-1:0] w_lin;
  logic          w_sof;
  logic          w_aceita;
  pixel_t        w_a;
  pixel_t        w_b;

`ifdef BUFFER_LINHAS_SOF_EN
  assign w_sof = inicio_quadro & pixel_valido;
`else
  assign w_sof = 1'b0;
`endif

  assign w_aceita = pixel_valido & ~reset;
  // A frame-start pixel is addressed as (0,0) before advancing
  assign w_col = w_sof ? '0 : r_col;
  assign w_lin = w_sof ? '0 : r_lin;

  memoria_linha #(.LARGURA(LARGURA)) u_mem_a (
    .clk    (clk),
    .i_we   (w_aceita),
    .i_addr (w_col),
    .i_dado (pixel_in),
    .o_dado (w_a)
  );

  memoria_linha #(.LARGURA(LARGURA)) u_mem_b (
    .clk    (clk),
    .i_we   (w_aceita),
    .i_addr (w_col),
    .i_dado (w_a),
    .o_dado (w_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_lin <= '0;
    end else if (pixel_valido) begin
      if (w_col == COL_MAX) begin
        r_col <= '0;
        r_lin <= (w_lin == LIN_MAX) ? '0 : w_lin + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_lin <= w_lin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      linha1        <= '0;
      linha2        <= '0;
      linha3        <= '0;
      janela_valida <= 1'b0;
    end else if (pixel_valido) begin
      linha1        <= {linha1[15:0], w_b};
      linha2        <= {linha2[15:0], w_a};
      linha3        <= {linha3[15:0], pixel_in};
      janela_valida <= (w_lin >= LW'(2)) && (w_col >= CW'(2));
    end else begin
      janela_valida <= 1'b0;
    end
  end

endmodule
